// File: rtl/weight_pingpong_shifter.sv
// -----------------------------------------------------------------------------
// weight_pingpong_shifter
//
// Double-buffered weight tile loader for a systolic array. Incoming beats
// (one weight per lane) fill one bank while the other bank drains. A full
// bank is drained as DEPTH contiguous beats, in load order or in reverse
// load order. Each lane's output can be skewed by k cycles to match the
// array's diagonal wavefront.
//
// State table (drain controller)
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no tile draining; waiting for drain_en and a full read bank
//   ST_DRAIN | presenting beats of bank rd_bank, drain_cnt counts down to 0
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   clear      in   synchronous flush of banks, counters and skew pipeline
//   in_valid   in   load beat offered
//   in_ready   out  load beat can be accepted
//   in_data    in   one beat, lane k at [k*DATA_W +: DATA_W]
//   drain_en   in   level, permits start of a tile drain
//   out_data   out  drained weights, lane-packed as in_data
//   out_valid  out  per-lane valid
//   out_last   out  per-lane final beat of the tile
//   full_cnt   out  number of full banks (0..2)
// -----------------------------------------------------------------------------
module weight_pingpong_shifter #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int LANES   = 4,
    parameter int SKEW    = 1,
    parameter int REVERSE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic                      drain_en,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic [LANES-1:0]          out_valid,
    output logic [LANES-1:0]          out_last,
    output logic [1:0]                full_cnt
);

    localparam int              CNT_W    = $clog2(DEPTH);
    localparam int              BEAT_W   = LANES * DATA_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   drain_cnt;
    logic [CNT_W-1:0]   drain_cnt_nxt;
    logic [CNT_W-1:0]   wr_cnt;
    logic [CNT_W-1:0]   rd_addr;
    logic [1:0]         full;
    logic               wr_bank;
    logic               rd_bank;
    logic               accept;
    logic               wr_done;
    logic               drain_tc;
    logic [BEAT_W-1:0]  rd_beat;
    logic               head_valid;
    logic               head_last;

    logic [BEAT_W-1:0]  mem [2][DEPTH];

    // ---------------------------------------------------------------- load side
    assign in_ready = !full[wr_bank] && !rst && !clear;
    assign accept   = in_valid && in_ready;
    assign wr_done  = accept && (wr_cnt == LAST_IDX);

    // Storage is never reset; the full flags alone decide what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank][wr_cnt] <= in_data;
        end
    end

    // ---------------------------------------------------------- drain control
    assign drain_tc = (state == ST_DRAIN) && (drain_cnt == '0);

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        case (state)
            ST_IDLE: begin
                if (drain_en && full[rd_bank]) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = LAST_IDX;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    // On the terminal cycle rd_bank has not toggled yet, so
                    // the next tile sits in the other bank. Chaining here
                    // gives back-to-back tiles with no bubble.
                    if (drain_en && full[~rd_bank]) begin
                        drain_cnt_nxt = LAST_IDX;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    drain_cnt_nxt = drain_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            full      <= 2'b00;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (accept) begin
                wr_cnt <= wr_done ? '0 : wr_cnt + 1'b1;
                if (wr_done) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (drain_tc) begin
                rd_bank <= ~rd_bank;
            end
            // A tile completing on one bank and a drain ending on the other
            // in the same cycle update independent flag bits.
            for (int b = 0; b < 2; b++) begin
                if (drain_tc && (rd_bank == 1'(b))) begin
                    full[b] <= 1'b0;
                end else if (wr_done && (wr_bank == 1'(b))) begin
                    full[b] <= 1'b1;
                end
            end
        end
    end

    // The counter runs DEPTH-1 down to 0; forward order mirrors it.
    assign rd_addr    = (REVERSE != 0) ? drain_cnt : (LAST_IDX - drain_cnt);
    assign head_valid = (state == ST_DRAIN);
    assign head_last  = drain_tc;
    assign rd_beat    = head_valid ? mem[rd_bank][rd_addr] : '0;

    // ---------------------------------------------------------- lane skewing
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int D = k * SKEW;

        logic [DATA_W-1:0] lane_d;
        logic              lane_v;
        logic              lane_l;

        if (D == 0) begin : g_direct
            assign lane_d = rd_beat[k*DATA_W +: DATA_W];
            assign lane_v = head_valid;
            assign lane_l = head_last;
        end else begin : g_delay
            // Data travels zeroed when invalid, so an idle lane drives zero.
            logic [DATA_W-1:0] d_q [D];
            logic [D-1:0]      v_q;
            logic [D-1:0]      l_q;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    for (int i = 0; i < D; i++) begin
                        d_q[i] <= '0;
                    end
                    v_q <= '0;
                    l_q <= '0;
                end else begin
                    d_q[0] <= rd_beat[k*DATA_W +: DATA_W];
                    v_q[0] <= head_valid;
                    l_q[0] <= head_last;
                    for (int i = 1; i < D; i++) begin
                        d_q[i] <= d_q[i-1];
                        v_q[i] <= v_q[i-1];
                        l_q[i] <= l_q[i-1];
                    end
                end
            end

            assign lane_d = d_q[D-1];
            assign lane_v = v_q[D-1];
            assign lane_l = l_q[D-1];
        end

        // rst forces quiet outputs even before the first reset edge lands.
        assign out_data[k*DATA_W +: DATA_W] = rst ? '0 : lane_d;
        assign out_valid[k]                 = !rst && lane_v;
        assign out_last[k]                  = !rst && lane_l;
    end

    assign full_cnt = rst ? 2'd0 : ({1'b0, full[0]} + {1'b0, full[1]});

endmodule

// File: doc/weight_pingpong_shifter.md
WEIGHT_PINGPONG_SHIFTER -- requirements
Module: weight_pingpong_shifter

Interface
REQ-001 Parameter DATA_W, default 8, bit width of one weight element.
REQ-002 Parameter DEPTH, default 8, beats per tile (array height); SHALL be >= 2.
REQ-003 Parameter LANES, default 4, parallel weight lanes (array columns); SHALL be >= 1.
REQ-004 Parameter SKEW, default 1; 1 = lane k output delayed k cycles, 0 = all lanes aligned.
REQ-005 Parameter REVERSE, default 1; 1 = last-loaded beat drained first, 0 = first-loaded beat drained first.
REQ-006 clk  input  1  single clock, all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 clear  input  1  synchronous flush of both banks and all counters; does not reset parameters.
REQ-009 in_valid  input  1  load beat offered.
REQ-010 in_ready  output  1  load beat can be accepted.
REQ-011 in_data  input  LANES*DATA_W  one beat; lane k at bits [k*DATA_W +: DATA_W].
REQ-012 drain_en  input  1  level; permits start of a tile drain.
REQ-013 out_data  output  LANES*DATA_W  drained weights, lane-packed as in_data.
REQ-014 out_valid  output  LANES  per-lane valid.
REQ-015 out_last  output  LANES  per-lane final beat of the tile.
REQ-016 full_cnt  output  2  number of full banks (0..2).

Function
REQ-017 Two banks of DEPTH x LANES x DATA_W storage, used ping-pong; write bank pointer wr_bank and read bank pointer rd_bank each toggle after its tile completes.
REQ-018 A beat SHALL be accepted exactly on cycles with in_valid && in_ready; in_ready = !full[wr_bank] && !rst && !clear.
REQ-019 Write counter counts accepted beats 0..DEPTH-1; on accepting beat DEPTH-1, full[wr_bank] sets (visible next cycle), counter wraps to 0, wr_bank toggles.
REQ-020 Drain start condition: drain_en && full[rd_bank] && not draining; drain then runs DEPTH consecutive cycles, non-stallable, ignoring drain_en.
REQ-021 Beat order: REVERSE=1 drains stored beats DEPTH-1 down to 0; REVERSE=0 drains 0 up to DEPTH-1.
REQ-022 Latency: start evaluated at cycle t -> lane 0 first beat at t+1; lane k first beat at t+1+k*SKEW; each lane then presents DEPTH contiguous beats.
REQ-023 On the last drain cycle full[rd_bank] clears (visible next cycle) and rd_bank toggles; a new drain MAY start on the immediately following cycle (back-to-back tiles, no bubble on lane 0).
REQ-024 Bank being drained SHALL not be written; a write completing a tile and a drain ending on the other bank in the same cycle SHALL both take effect.
REQ-025 Fill-to-drain: last beat accepted at t, drain_en high -> lane 0 first output at t+2.
REQ-026 Lanes not valid SHALL drive zero on their out_data slice; out_last[k] high only with out_valid[k] on lane k's DEPTH-th beat.
REQ-027 Skew implemented as per-lane delay registers carrying data, valid and last; skew pipeline continues draining after the bank is released.
REQ-028 clear: same cycle in_ready=0, beat ignored; next cycle both banks empty, counters and pointers 0, drain aborted, skew pipeline zeroed.
REQ-029 full_cnt = full[0]+full[1], registered state, no glitch.

Reset
REQ-030 While rst high: in_ready=0, out_data=0, out_valid=0, out_last=0, full_cnt=0; rst overrides clear, in_valid, drain_en.
REQ-031 First cycle after rst low: in_ready=1, both banks empty, wr_bank=rd_bank=0, no drain active; storage contents need not be zeroed.
REQ-032 rst mid-load or mid-drain SHALL discard partial tile and in-flight skewed outputs.

Verification (DATA_W=8, DEPTH=4, LANES=2, SKEW=1, REVERSE=1 unless stated)
REQ-033 Load beats 0x0101,0x0202,0x0303,0x0404 then drain_en -> lane0 04,03,02,01 on cycles t+1..t+4, lane1 same values t+2..t+5, out_last at lane0 t+4, lane1 t+5.
REQ-034 REVERSE=0, SKEW=0, same load -> both lanes 01,02,03,04 aligned, out_valid=2'b11 for 4 cycles.
REQ-035 Load 3 tiles with drain_en=0 -> in_ready drops after beat 8, full_cnt=2, 9th beat held; raise drain_en -> in_ready rises the cycle after drain ends, tile 3 accepted.
REQ-036 drain_en held high, continuous in_valid -> tiles drain back-to-back, lane0 out_valid never drops between tiles after first fill.
REQ-037 clear pulse mid-drain (beat 2) -> next cycle all out_valid=0, full_cnt=0, in_ready=1; subsequent tile loads and drains correctly.
REQ-038 rst pulse after 2 loaded beats -> outputs 0 during reset; 4 new beats then drain yield only the new values.
